qspi_flash_ctrl: RTL and testbench

- Sequences the external quad-SPI flash for the instruction cache.
- Accepts one line-fill request (24-bit byte address, single-cycle read enable) from the cache miss path.
- Issues a Quad I/O Fast Read (0xEB) on the flash pins and returns WORDS 32-bit words as single-cycle valid pulses, in the order the cache line-fill counter expects.
- Reports readiness so the cache accepts new AXI reads only when the flash port is free.

---
 rtl/qspi_flash_pkg.sv | 26 ++
 rtl/qspi_sck_gen.sv | 38 +++
 rtl/qspi_flash_ctrl.sv | 141 ++++++++++++++
 tb/tb_qspi_flash_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_flash_pkg.sv
// Shared types and constants for the quad-SPI line-fill controller.
// Holds the FSM encoding, the fast-read command bytes and the phase lengths.
package qspi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_MODE,
    ST_DUMMY,
    ST_DATA,
    ST_CSHI
  } qspi_state_e;

  localparam logic [7:0] CMD_QUAD_IO_READ = 8'hEB;
  localparam logic [7:0] MODE_BYTE        = 8'h00;
  localparam int         ADDR_NIBBLES     = 6;
  localparam int         CMD_BITS         = 8;
  localparam int         MODE_NIBBLES     = 2;

  // Bit offset of data nibble j inside a little-endian word, high nibble of each byte first.
  function automatic logic [4:0] nib_pos(input logic [2:0] j);
    return {j[1 +: 2], ~j[0], 2'b00};
  endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// SPI mode-0 clock divider; strobes flag the aclk cycle at whose end sck rises or falls.
// Zero latency from enable; disabled means sck low and divider cleared.
module qspi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       tick;

  assign tick     = en && (cnt == DIV_LAST);
  assign rise_stb = tick && !sck;
  assign fall_stb = tick && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= 8'd0;
      sck <= 1'b0;
    end else if (tick) begin
      cnt <= 8'd0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/qspi_flash_ctrl.sv
// Quad I/O fast-read (0xEB) line-fill sequencer; one request in flight, rready only in IDLE.
// Returns WORDS little-endian words as single-cycle dval pulses, then holds cs_n high CS_HIGH_MIN cycles.
module qspi_flash_ctrl
  import qspi_flash_pkg::*;
#(
  parameter int CLK_DIV      = 1,
  parameter int DUMMY_CYCLES = 4,
  parameter int WORDS        = 4,
  parameter int CS_HIGH_MIN  = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [23:0] qspi_addr,
  input  logic        qspi_read_en,
  output logic        qspi_rready,
  output logic [31:0] qspi_dout,
  output logic        qspi_dval,
  output logic        flash_sck,
  output logic        flash_cs_n,
  output logic [3:0]  flash_io_o,
  output logic [3:0]  flash_io_oe,
  input  logic [3:0]  flash_io_i
);

  localparam int             WCW        = $clog2(WORDS) + 1;
  localparam logic [WCW-1:0] WORDS_W    = WCW'(WORDS);
  localparam logic [5:0]     CMD_LAST   = 6'(CMD_BITS - 1);
  localparam logic [5:0]     ADDR_LAST  = 6'(ADDR_NIBBLES - 1);
  localparam logic [5:0]     MODE_LAST  = 6'(MODE_NIBBLES - 1);
  localparam logic [5:0]     DUMMY_LAST = (DUMMY_CYCLES == 0) ? 6'd0 : 6'(DUMMY_CYCLES - 1);
  localparam logic [5:0]     CSHI_LAST  = (CS_HIGH_MIN == 0) ? 6'd0 : 6'(CS_HIGH_MIN - 1);

  qspi_state_e    state, state_nxt;
  logic [5:0]     bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic [23:0]    addr_q;
  logic [31:0]    rx, rx_nxt;
  logic           sck_en, rise_stb, fall_stb;

  qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk      (aclk),
    .rst_n    (aresetn),
    .en       (sck_en),
    .sck      (flash_sck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Serial phases advance only on a fall boundary, so each new bit is launched as sck drops.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (qspi_read_en) state_nxt = ST_CMD;
      ST_CMD:   if (fall_stb && bit_cnt == CMD_LAST) state_nxt = ST_ADDR;
      ST_ADDR:  if (fall_stb && bit_cnt == ADDR_LAST) state_nxt = ST_MODE;
      ST_MODE:  if (fall_stb && bit_cnt == MODE_LAST)
                  state_nxt = (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
      ST_DUMMY: if (fall_stb && bit_cnt == DUMMY_LAST) state_nxt = ST_DATA;
      ST_DATA:  if (fall_stb && bit_cnt == 6'd7 && word_cnt == WORDS_W) state_nxt = ST_CSHI;
      ST_CSHI:  if (bit_cnt == CSHI_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    qspi_rready = (state == ST_IDLE);
    sck_en      = 1'b0;
    flash_io_oe = 4'h0;
    flash_io_o  = 4'h0;
    case (state)
      ST_CMD: begin
        sck_en      = 1'b1;
        flash_io_oe = 4'b0001;
        flash_io_o  = {3'b000, CMD_QUAD_IO_READ[~bit_cnt[2:0]]};
      end
      ST_ADDR: begin
        sck_en      = 1'b1;
        flash_io_oe = 4'hF;
        case (bit_cnt[2:0])
          3'd0:    flash_io_o = addr_q[23:20];
          3'd1:    flash_io_o = addr_q[19:16];
          3'd2:    flash_io_o = addr_q[15:12];
          3'd3:    flash_io_o = addr_q[11:8];
          3'd4:    flash_io_o = addr_q[7:4];
          3'd5:    flash_io_o = addr_q[3:0];
          default: flash_io_o = 4'h0;
        endcase
      end
      ST_MODE: begin
        sck_en      = 1'b1;
        flash_io_oe = 4'hF;
        flash_io_o  = bit_cnt[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
      end
      ST_DUMMY, ST_DATA: sck_en = 1'b1;
      default: ;
    endcase
    flash_cs_n = !sck_en;
  end

  always_comb begin
    rx_nxt = rx;
    rx_nxt[nib_pos(bit_cnt[2:0]) +: 4] = flash_io_i;
  end

  // In DATA the bit counter wraps per word so bit_cnt[2:0] is the nibble index within the word.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bit_cnt   <= 6'd0;
      word_cnt  <= '0;
      addr_q    <= 24'd0;
      rx        <= 32'd0;
      qspi_dout <= 32'd0;
      qspi_dval <= 1'b0;
    end else begin
      qspi_dval <= 1'b0;
      if (state == ST_IDLE && qspi_read_en) addr_q <= qspi_addr;
      if (state == ST_DATA && rise_stb) begin
        rx <= rx_nxt;
        if (bit_cnt[2:0] == 3'd7) begin
          qspi_dout <= rx_nxt;
          qspi_dval <= 1'b1;
          word_cnt  <= word_cnt + WCW'(1);
        end
      end
      if (state_nxt != state) begin
        bit_cnt  <= 6'd0;
        word_cnt <= '0;
      end else if (state == ST_CSHI) begin
        bit_cnt <= bit_cnt + 6'd1;
      end else if (fall_stb) begin
        bit_cnt <= (state == ST_DATA && bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// Directed bench: two controllers (defaults, and CLK_DIV=3/no dummy) against a behavioural quad flash.
module tb_qspi_flash_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [23:0] addr [2];
  logic        ren [2];
  logic        rready [2];
  logic [31:0] dout [2];
  logic        dval [2];
  logic        sck [2];
  logic        cs_n [2];
  logic [3:0]  io_o [2];
  logic [3:0]  io_oe [2];
  logic [3:0]  io_i [2] = '{default: 4'h0};

  logic [7:0]  mem [256];
  int          cyc;
  int          rises [2];
  int          nw [2];
  int          hi_wait [2];
  int          gap_run [2];
  int          gap [2];
  int          per_min [2];
  int          per_max [2];
  int          last_rise [2];
  int          oe_bad [2];
  logic [7:0]  cmd_cap [2];
  logic [7:0]  mode_cap [2];
  logic [23:0] adr_cap [2];
  logic [31:0] words [2][8];
  logic        prev_sck [2] = '{default: 1'b0};
  logic        prev_cs [2] = '{default: 1'b1};

  int ntot = 0;
  int npass = 0;
  int nfail = 0;

  logic [31:0] exp_a [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

  always #5 aclk = ~aclk;

  qspi_flash_ctrl #(.CLK_DIV(1), .DUMMY_CYCLES(4), .WORDS(4), .CS_HIGH_MIN(2)) u0 (
    .aclk(aclk), .aresetn(aresetn), .qspi_addr(addr[0]), .qspi_read_en(ren[0]),
    .qspi_rready(rready[0]), .qspi_dout(dout[0]), .qspi_dval(dval[0]),
    .flash_sck(sck[0]), .flash_cs_n(cs_n[0]), .flash_io_o(io_o[0]),
    .flash_io_oe(io_oe[0]), .flash_io_i(io_i[0])
  );

  qspi_flash_ctrl #(.CLK_DIV(3), .DUMMY_CYCLES(0), .WORDS(4), .CS_HIGH_MIN(2)) u1 (
    .aclk(aclk), .aresetn(aresetn), .qspi_addr(addr[1]), .qspi_read_en(ren[1]),
    .qspi_rready(rready[1]), .qspi_dout(dout[1]), .qspi_dval(dval[1]),
    .flash_sck(sck[1]), .flash_cs_n(cs_n[1]), .flash_io_o(io_o[1]),
    .flash_io_oe(io_oe[1]), .flash_io_i(io_i[1])
  );

  function automatic int dummy_of(input int g);
    return (g == 0) ? 4 : 0;
  endfunction

  function automatic logic [3:0] oe_exp(input int r);
    if (r < 8)  return 4'h1;
    if (r < 16) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [3:0] flash_nib(input int g);
    int         k;
    logic [7:0] b;
    k = rises[g] - 16 - dummy_of(g);
    b = mem[8'(adr_cap[g][7:0] + 8'(k / 2))];
    return k[0] ? b[3:0] : b[7:4];
  endfunction

  // Flash model and pin monitor, evaluated away from the active edge.
  always @(negedge aclk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      prev_sck[g] <= sck[g];
      prev_cs[g]  <= cs_n[g];
      if (prev_cs[g] && !cs_n[g]) begin
        rises[g]   <= 0;
        nw[g]      <= 0;
        hi_wait[g] <= 0;
        gap[g]     <= gap_run[g];
        gap_run[g] <= 0;
        per_min[g] <= 1000;
        per_max[g] <= 0;
        oe_bad[g]  <= 0;
      end else begin
        if (cs_n[g]) gap_run[g] <= gap_run[g] + 1;
        if (cs_n[g] && !rready[g]) hi_wait[g] <= hi_wait[g] + 1;
        if (sck[g] && !prev_sck[g]) begin
          rises[g]     <= rises[g] + 1;
          last_rise[g] <= cyc;
          if (rises[g] > 0) begin
            per_min[g] <= (cyc - last_rise[g] < per_min[g]) ? cyc - last_rise[g] : per_min[g];
            per_max[g] <= (cyc - last_rise[g] > per_max[g]) ? cyc - last_rise[g] : per_max[g];
          end
          if (rises[g] < 8)       cmd_cap[g]  <= {cmd_cap[g][6:0], io_o[g][0]};
          else if (rises[g] < 14) adr_cap[g]  <= {adr_cap[g][19:0], io_o[g]};
          else if (rises[g] < 16) mode_cap[g] <= {mode_cap[g][3:0], io_o[g]};
          if (io_oe[g] !== oe_exp(rises[g])) oe_bad[g] <= oe_bad[g] + 1;
        end
        if (!sck[g] && prev_sck[g] && !cs_n[g] && rises[g] >= 16 + dummy_of(g))
          io_i[g] <= flash_nib(g);
        if (dval[g]) begin
          words[g][nw[g][2:0]] <= dout[g];
          nw[g] <= nw[g] + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) begin
      npass++;
    end else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int g, input logic [23:0] a);
    addr[g] = a;
    ren[g]  = 1'b1;
    @(negedge aclk);
    ren[g]  = 1'b0;
    addr[g] = 24'h0;
  endtask

  task automatic wait_done(input int g, input string tag);
    int n;
    n = 0;
    while (!rready[g] && n < 4000) begin
      @(negedge aclk);
      n++;
    end
    chk({tag, "_done"}, 32'(rready[g]), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i - 'h30);
    mem[8'h40] = 8'hA5;
    mem[8'h41] = 8'h5A;
    mem[8'h42] = 8'hC3;
    mem[8'h43] = 8'h3C;
    ren[0] = 1'b0;
    ren[1] = 1'b0;
    addr[0] = 24'h0;
    addr[1] = 24'h0;

    repeat (3) @(negedge aclk);
    chk("rst_cs_n", 32'(cs_n[0]), 32'd1);
    chk("rst_sck", 32'(sck[0]), 32'd0);
    chk("rst_oe", 32'(io_oe[0]), 32'd0);
    chk("rst_io_o", 32'(io_o[0]), 32'd0);
    chk("rst_dval", 32'(dval[0]), 32'd0);
    chk("rst_dout", dout[0], 32'd0);
    chk("rst_rready", 32'(rready[0]), 32'd1);
    chk("rst_rready_u1", 32'(rready[1]), 32'd1);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    start(0, 24'h001230);
    wait_done(0, "t1");
    chk("t1_cmd", 32'(cmd_cap[0]), 32'hEB);
    chk("t1_addr", 32'(adr_cap[0]), 32'h001230);
    chk("t1_mode", 32'(mode_cap[0]), 32'h00);
    chk("t1_rises", 32'(rises[0]), 32'd52);
    chk("t1_oe", 32'(oe_bad[0]), 32'd0);
    chk("t1_nwords", 32'(nw[0]), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_word%0d", i), words[0][i], exp_a[i]);
    chk("t1_cshi", 32'(hi_wait[0]), 32'd2);
    chk("t1_period", 32'(per_max[0]), 32'd2);

    start(1, 24'h001230);
    wait_done(1, "t2");
    chk("t2_cmd", 32'(cmd_cap[1]), 32'hEB);
    chk("t2_addr", 32'(adr_cap[1]), 32'h001230);
    chk("t2_rises", 32'(rises[1]), 32'd48);
    chk("t2_per_min", 32'(per_min[1]), 32'd6);
    chk("t2_per_max", 32'(per_max[1]), 32'd6);
    chk("t2_oe", 32'(oe_bad[1]), 32'd0);
    chk("t2_nwords", 32'(nw[1]), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_word%0d", i), words[1][i], exp_a[i]);

    start(0, 24'h001230);
    repeat (2) @(negedge aclk);
    n = 0;
    while (rises[0] < 10 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    chk("t3_reach_addr", 32'(rises[0] >= 10), 32'd1);
    start(0, 24'hFFFFF0);
    wait_done(0, "t3");
    chk("t3_addr", 32'(adr_cap[0]), 32'h001230);
    chk("t3_nwords", 32'(nw[0]), 32'd4);
    chk("t3_word0", words[0][0], 32'h03020100);
    chk("t3_word3", words[0][3], 32'h0F0E0D0C);
    repeat (20) @(negedge aclk);
    chk("t3_no_queue", 32'(cs_n[0]), 32'd1);

    start(0, 24'h001230);
    wait_done(0, "t4a");
    chk("t4a_nwords", 32'(nw[0]), 32'd4);
    chk("t4a_word3", words[0][3], 32'h0F0E0D0C);
    start(0, 24'h000040);
    wait_done(0, "t4b");
    chk("t4_gap", 32'(gap[0]), 32'd3);
    chk("t4b_addr", 32'(adr_cap[0]), 32'h000040);
    chk("t4b_word0", words[0][0], 32'h3CC35AA5);
    chk("t4b_word1", words[0][1], 32'h17161514);
    chk("t4b_nwords", 32'(nw[0]), 32'd4);

    start(0, 24'h001230);
    repeat (2) @(negedge aclk);
    n = 0;
    while (nw[0] < 2 && n < 1000) begin
      @(negedge aclk);
      n++;
    end
    chk("t5_two_words", 32'(nw[0]), 32'd2);
    repeat (3) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("t5_cs_n", 32'(cs_n[0]), 32'd1);
    chk("t5_sck", 32'(sck[0]), 32'd0);
    chk("t5_oe", 32'(io_oe[0]), 32'd0);
    chk("t5_dval", 32'(dval[0]), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (200) @(negedge aclk);
    chk("t5_no_more_dval", 32'(nw[0]), 32'd2);
    chk("t5_rready", 32'(rready[0]), 32'd1);
    chk("t5_idle_cs", 32'(cs_n[0]), 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
